// File: rtl/bldc_pkg.sv
// Shared types and constants for the hall-sensor six-step commutator.
// Holds the FSM state encoding, the sector codes and the forward drive table.
// The table is indexed by sector; reverse drive swaps the hs/ls columns.
package bldc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEAD  = 3'd1,
    ST_DRIVE = 3'd2,
    ST_FAULT = 3'd3,
    ST_STALL = 3'd4
  } state_e;

  localparam logic [2:0] SECTOR_0       = 3'd0;
  localparam logic [2:0] SECTOR_1       = 3'd1;
  localparam logic [2:0] SECTOR_2       = 3'd2;
  localparam logic [2:0] SECTOR_3       = 3'd3;
  localparam logic [2:0] SECTOR_4       = 3'd4;
  localparam logic [2:0] SECTOR_5       = 3'd5;
  localparam logic [2:0] SECTOR_INVALID = 3'd7;

  // Phase one-hots are {C,B,A}; entry n drives sector n in forward direction.
  localparam logic [2:0] FWD_HS [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
  localparam logic [2:0] FWD_LS [6] = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};

  // Gray-like hall pattern to sector; all-zero and all-one patterns are sensor faults.
  function automatic logic [2:0] hall_to_sector(input logic [2:0] h);
    case (h)
      3'b101:  hall_to_sector = SECTOR_0;
      3'b100:  hall_to_sector = SECTOR_1;
      3'b110:  hall_to_sector = SECTOR_2;
      3'b010:  hall_to_sector = SECTOR_3;
      3'b011:  hall_to_sector = SECTOR_4;
      3'b001:  hall_to_sector = SECTOR_5;
      default: hall_to_sector = SECTOR_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/hall_edge_sync.sv
// Two-flop synchroniser for the raw hall pins plus one delay stage for edge detect.
// Latency: hs_o two cycles after a raw change, chg_o high for one cycle alongside it.
// No backpressure; free-running every clock.
module hall_edge_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] hall_i,
  output logic [2:0] hs_o,
  output logic       chg_o
);

  logic [2:0] s1_q;
  logic [2:0] hs_q;
  logic [2:0] hq_q;

  // Synchroniser chain followed by the one-cycle-old copy used for change detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= 3'b000;
      hs_q <= 3'b000;
      hq_q <= 3'b000;
    end else begin
      s1_q <= hall_i;
      hs_q <= s1_q;
      hq_q <= hs_q;
    end
  end

  assign hs_o  = hs_q;
  assign chg_o = (hs_q != hq_q);

endmodule

// File: rtl/bldc_hall_commutator.sv
// Six-step BLDC commutator: hall sync, dead time on each commutation, gate drive, period measure.
// Latency: gates react one cycle after chg; gate_hs follows pwm_in with one cycle of delay.
// No backpressure; invalid halls and stalls latch sticky flags that only enable=0 clears.
module bldc_hall_commutator
  import bldc_pkg::*;
#(
  parameter int CNT_W        = 24,
  parameter int DEAD_CYCLES  = 8,
  parameter int STALL_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             dir,
  input  logic [2:0]       hall,
  input  logic             pwm_in,
  output logic [2:0]       gate_hs,
  output logic [2:0]       gate_ls,
  output logic [2:0]       sector,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             stall,
  output logic             fault
);

  localparam int                DW         = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0]     DEAD_LOAD  = DW'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STALL_LAST = CNT_W'(STALL_CYCLES - 1);

  logic [2:0]       hs;
  logic             chg;
  logic [2:0]       sec;
  logic             sec_ok;
  logic [2:0]       sec_idx;
  logic [2:0]       tbl_hs;
  logic [2:0]       tbl_ls;
  logic [CNT_W-1:0] cnt_inc;
  logic             stall_hit;

  state_e           state_q;
  logic [DW-1:0]    dead_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q;
  logic             pv_q;
  logic             first_q;
  logic             stall_q;
  logic             fault_q;
  logic [2:0]       ghs_q;
  logic [2:0]       gls_q;

  hall_edge_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .hall_i  (hall),
    .hs_o    (hs),
    .chg_o   (chg)
  );

  assign sec       = hall_to_sector(hs);
  assign sec_ok    = (sec != SECTOR_INVALID);
  assign sec_idx   = sec_ok ? sec : SECTOR_0;
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  // The counter would reach the stall limit on this edge.
  assign stall_hit = (cnt_q >= STALL_LAST);

  // Drive table lookup; reverse direction swaps the high and low side phases.
  always_comb begin
    tbl_hs = FWD_HS[sec_idx];
    tbl_ls = FWD_LS[sec_idx];
    if (dir) begin
      tbl_hs = FWD_LS[sec_idx];
      tbl_ls = FWD_HS[sec_idx];
    end
  end

  // Commutation FSM with registered gates, period capture and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      dead_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      first_q  <= 1'b1;
      stall_q  <= 1'b0;
      fault_q  <= 1'b0;
      ghs_q    <= 3'b000;
      gls_q    <= 3'b000;
    end else begin
      pv_q  <= 1'b0;
      ghs_q <= 3'b000;
      gls_q <= 3'b000;
      if (!enable) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        first_q <= 1'b1;
        stall_q <= 1'b0;
        fault_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_DEAD;
            dead_q  <= DEAD_LOAD;
          end
          ST_DEAD, ST_DRIVE: begin
            cnt_q <= cnt_inc;
            if (!sec_ok) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end else if (chg) begin
              // Commutation: restart dead time and close the period measurement.
              state_q <= ST_DEAD;
              dead_q  <= DEAD_LOAD;
              cnt_q   <= '0;
              first_q <= 1'b0;
              if (!first_q) begin
                period_q <= cnt_inc;
                pv_q     <= 1'b1;
              end
            end else if (state_q == ST_DEAD) begin
              if (dead_q == '0) begin
                state_q <= ST_DRIVE;
                ghs_q   <= tbl_hs & {3{pwm_in}};
                gls_q   <= tbl_ls;
              end else begin
                dead_q <= dead_q - 1'b1;
              end
            end else if (stall_hit) begin
              state_q <= ST_STALL;
              stall_q <= 1'b1;
            end else begin
              ghs_q <= tbl_hs & {3{pwm_in}};
              gls_q <= tbl_ls;
            end
          end
          default: begin
            // FAULT and STALL park with gates off until enable drops.
            cnt_q <= cnt_inc;
          end
        endcase
      end
    end
  end

  assign gate_hs      = ghs_q;
  assign gate_ls      = gls_q;
  assign sector       = sec;
  assign period_out   = period_q;
  assign period_valid = pv_q;
  assign stall        = stall_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_bldc_hall_commutator.sv
module tb_bldc_hall_commutator;

  localparam int CNT_W = 16;
  localparam int DEAD  = 4;
  localparam int STALL = 100;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             dir = 1'b0;
  logic             pwm_in = 1'b1;
  logic [2:0]       hall = 3'b101;
  logic [2:0]       gate_hs;
  logic [2:0]       gate_ls;
  logic [2:0]       sector;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             stall;
  logic             fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bldc_hall_commutator #(
    .CNT_W        (CNT_W),
    .DEAD_CYCLES  (DEAD),
    .STALL_CYCLES (STALL)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .dir          (dir),
    .hall         (hall),
    .pwm_in       (pwm_in),
    .gate_hs      (gate_hs),
    .gate_ls      (gate_ls),
    .sector       (sector),
    .period_out   (period_out),
    .period_valid (period_valid),
    .stall        (stall),
    .fault        (fault)
  );

  // Hall pattern for sectors 0..5, in rotation order.
  int codes[6] = '{5, 4, 6, 2, 3, 1};

  // Reference model: modes 0 idle, 1 dead, 2 drive, 3 fault, 4 stall.
  int         m_mode = 0;
  int         m_since = 0;
  int         m_cnt = 0;
  int         m_per = 0;
  bit         m_first = 1'b1;
  bit         m_pv = 1'b0;
  bit         m_stall = 1'b0;
  bit         m_fault = 1'b0;
  logic [2:0] m_p1 = 3'b000;
  logic [2:0] m_p2 = 3'b000;
  logic [2:0] m_p3 = 3'b000;
  logic [2:0] m_ghs = 3'b000;
  logic [2:0] m_gls = 3'b000;

  function automatic int sec_of(logic [2:0] h);
    for (int i = 0; i < 6; i++) if (int'(h) == codes[i]) return i;
    return -1;
  endfunction

  function automatic int sat(int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic model_edge();
    int s;
    bit ch;
    int hp;
    int lp;
    int t;
    s  = sec_of(m_p2);
    ch = (m_p2 != m_p3);
    m_pv = 1'b0;
    if (!reset_n) begin
      m_mode = 0; m_since = 0; m_cnt = 0; m_per = 0; m_first = 1'b1;
      m_stall = 1'b0; m_fault = 1'b0;
      m_p1 = 3'b000; m_p2 = 3'b000; m_p3 = 3'b000;
    end else begin
      if (!enable) begin
        m_mode = 0; m_cnt = 0; m_first = 1'b1; m_stall = 1'b0; m_fault = 1'b0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_since = 0;
      end else if (m_mode >= 3) begin
        m_cnt = sat(m_cnt + 1);
      end else if (s < 0) begin
        m_mode = 3; m_fault = 1'b1; m_cnt = sat(m_cnt + 1);
      end else if (ch) begin
        if (!m_first) begin
          m_per = sat(m_cnt + 1);
          m_pv  = 1'b1;
        end
        m_first = 1'b0; m_cnt = 0; m_mode = 1; m_since = 0;
      end else if (m_mode == 2 && m_cnt + 1 >= STALL) begin
        m_mode = 4; m_stall = 1'b1; m_cnt = sat(m_cnt + 1);
      end else begin
        m_cnt = sat(m_cnt + 1);
        if (m_mode == 1) begin
          m_since++;
          if (m_since >= DEAD) m_mode = 2;
        end
      end
      m_p3 = m_p2; m_p2 = m_p1; m_p1 = hall;
    end
    m_ghs = 3'b000;
    m_gls = 3'b000;
    if (m_mode == 2) begin
      hp = s / 2;
      lp = (s / 2 + 1 + s % 2) % 3;
      if (dir) begin
        t = hp; hp = lp; lp = t;
      end
      m_ghs = pwm_in ? 3'(1 << hp) : 3'b000;
      m_gls = 3'(1 << lp);
    end
  endtask

  task automatic check_model();
    logic [2:0] es;
    es = (sec_of(m_p2) < 0) ? 3'd7 : 3'(sec_of(m_p2));
    n_cmp++;
    if (gate_hs !== m_ghs || gate_ls !== m_gls || sector !== es ||
        period_out !== CNT_W'(m_per) || period_valid !== m_pv ||
        stall !== m_stall || fault !== m_fault) begin
      n_bad++;
      $display("FAIL model t=%0t got/want: hs %b/%b ls %b/%b sec %0d/%0d per %0d/%0d pv %b/%b stall %b/%b fault %b/%b",
               $time, gate_hs, m_ghs, gate_ls, m_gls, sector, es, period_out, m_per,
               period_valid, m_pv, stall, m_stall, fault, m_fault);
    end
    n_cmp++;
    if ((gate_hs & gate_ls) != 3'b000) begin
      n_bad++;
      $display("FAIL shoot_through t=%0t hs=%b ls=%b overlap must be 000", $time, gate_hs, gate_ls);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] hall;
    logic       dir;
    logic [2:0] sec;
    logic [2:0] ghs;
    logic [2:0] gls;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{3'b101, 1'b0, 3'd0, 3'b001, 3'b010};
    vt[1]  = '{3'b100, 1'b0, 3'd1, 3'b001, 3'b100};
    vt[2]  = '{3'b110, 1'b0, 3'd2, 3'b010, 3'b100};
    vt[3]  = '{3'b010, 1'b0, 3'd3, 3'b010, 3'b001};
    vt[4]  = '{3'b011, 1'b0, 3'd4, 3'b100, 3'b001};
    vt[5]  = '{3'b001, 1'b0, 3'd5, 3'b100, 3'b010};
    vt[6]  = '{3'b101, 1'b1, 3'd0, 3'b010, 3'b001};
    vt[7]  = '{3'b100, 1'b1, 3'd1, 3'b100, 3'b001};
    vt[8]  = '{3'b110, 1'b1, 3'd2, 3'b100, 3'b010};
    vt[9]  = '{3'b010, 1'b1, 3'd3, 3'b001, 3'b010};
    vt[10] = '{3'b011, 1'b1, 3'd4, 3'b001, 3'b100};
    vt[11] = '{3'b001, 1'b1, 3'd5, 3'b010, 3'b100};

    // Reset state.
    repeat (3) tick();
    expect_eq("rst_gate_hs", 32'(gate_hs), 0);
    expect_eq("rst_gate_ls", 32'(gate_ls), 0);
    expect_eq("rst_sector", 32'(sector), 7);
    expect_eq("rst_period", 32'(period_out), 0);
    expect_eq("rst_flags", {29'd0, period_valid, stall, fault}, 0);
    reset_n = 1'b1;
    repeat (4) tick();

    // Enable: four dead cycles then drive sector 0.
    enable = 1'b1;
    for (int i = 0; i < DEAD; i++) begin
      tick();
      expect_eq("dead_gates", {26'd0, gate_hs, gate_ls}, 0);
    end
    tick();
    expect_eq("s0_hs", 32'(gate_hs), 32'b001);
    expect_eq("s0_ls", 32'(gate_ls), 32'b010);
    expect_eq("s0_sector", 32'(sector), 0);

    // Hall steps 50 cycles apart.
    hall = 3'b100;
    repeat (3) tick();
    expect_eq("chg1_gates_off", {26'd0, gate_hs, gate_ls}, 0);
    expect_eq("chg1_no_pv", 32'(period_valid), 0);
    repeat (3) begin
      tick();
      expect_eq("chg1_dead", {26'd0, gate_hs, gate_ls}, 0);
    end
    tick();
    expect_eq("s1_hs", 32'(gate_hs), 32'b001);
    expect_eq("s1_ls", 32'(gate_ls), 32'b100);
    repeat (43) tick();
    hall = 3'b110;
    repeat (3) tick();
    expect_eq("chg2_pv", 32'(period_valid), 1);
    expect_eq("chg2_period", 32'(period_out), 50);
    repeat (4) tick();
    expect_eq("s2_hs", 32'(gate_hs), 32'b010);
    expect_eq("s2_ls", 32'(gate_ls), 32'b100);
    expect_eq("s2_sector", 32'(sector), 2);

    // Reverse at sector 0 and pwm gating of the high side only.
    hall = 3'b101;
    dir  = 1'b1;
    repeat (7) tick();
    expect_eq("rev_hs", 32'(gate_hs), 32'b010);
    expect_eq("rev_ls", 32'(gate_ls), 32'b001);
    pwm_in = 1'b0;
    tick();
    expect_eq("pwm0_hs", 32'(gate_hs), 0);
    expect_eq("pwm0_ls", 32'(gate_ls), 32'b001);
    pwm_in = 1'b1;
    tick();
    expect_eq("pwm1_hs", 32'(gate_hs), 32'b010);

    // Invalid hall faults and holds until enable drops.
    hall = 3'b111;
    repeat (3) tick();
    expect_eq("fault_set", 32'(fault), 1);
    expect_eq("fault_gates", {26'd0, gate_hs, gate_ls}, 0);
    repeat (10) tick();
    expect_eq("fault_held", 32'(fault), 1);
    enable = 1'b0;
    tick();
    expect_eq("fault_clear", 32'(fault), 0);
    hall = 3'b101;
    dir  = 1'b0;
    repeat (5) tick();

    // Frozen hall stalls.
    enable = 1'b1;
    repeat (120) tick();
    expect_eq("stall_set", 32'(stall), 1);
    expect_eq("stall_gates", {26'd0, gate_hs, gate_ls}, 0);
    enable = 1'b0;
    tick();
    expect_eq("stall_clear", 32'(stall), 0);

    // Hall change coinciding with the timeout wins.
    enable = 1'b1;
    repeat (10) tick();
    hall = 3'b100;
    repeat (100) tick();
    hall = 3'b110;
    repeat (3) tick();
    expect_eq("tie_period", 32'(period_out), 100);
    expect_eq("tie_pv", 32'(period_valid), 1);
    expect_eq("tie_no_stall", 32'(stall), 0);
    repeat (7) tick();
    expect_eq("tie_hs", 32'(gate_hs), 32'b010);
    expect_eq("tie_ls", 32'(gate_ls), 32'b100);

    // Reset in the middle of DRIVE.
    reset_n = 1'b0;
    enable  = 1'b0;
    tick();
    expect_eq("mid_rst_gates", {26'd0, gate_hs, gate_ls}, 0);
    expect_eq("mid_rst_sector", 32'(sector), 7);
    expect_eq("mid_rst_period", 32'(period_out), 0);
    expect_eq("mid_rst_flags", {29'd0, period_valid, stall, fault}, 0);
    reset_n = 1'b1;
    repeat (4) tick();
    enable = 1'b1;
    repeat (8) tick();
    expect_eq("reentry_hs", 32'(gate_hs), 32'b010);
    hall = 3'b011;
    repeat (3) tick();
    expect_eq("reentry_no_pv", 32'(period_valid), 0);
    repeat (5) tick();

    // Table of every sector in both directions.
    for (int i = 0; i < 12; i++) begin
      hall = vt[i].hall;
      dir  = vt[i].dir;
      repeat (9) tick();
      expect_eq("tbl_sector", 32'(sector), 32'(vt[i].sec));
      expect_eq("tbl_hs", 32'(gate_hs), 32'(vt[i].ghs));
      expect_eq("tbl_ls", 32'(gate_ls), 32'(vt[i].gls));
    end

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) hall = 3'(codes[$urandom_range(0, 5)]);
      if ($urandom_range(0, 399) == 0) hall = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
      if ($urandom_range(0, 3) == 0) pwm_in = ~pwm_in;
      if ($urandom_range(0, 499) == 0) dir = ~dir;
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
      reset_n = ($urandom_range(0, 1999) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
